dmem_bus_responder: RTL and testbench

Memory-side responder for the core's load/store port. It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. It then returns read data or a write acknowledge over a second valid/ready handshake. The block decodes a word-addressed RAM region plus two MMIO registers (LED output, switch input), and replaces the core's combinational data memory once the LSU moves to a handshaked bus.

---
 rtl/rv32_pkg.sv | 21 ++
 rtl/sync2.sv | 27 ++
 rtl/dmem_bus_responder.sv | 168 ++++++++++++++++
 tb/tb_dmem_bus_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared types for the core's memory-side bus.
// Holds bus FSM states, the latched request bundle and MMIO defaults.
package rv32_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } bus_state_t;

  localparam logic [31:0] LED_ADDR_DEF = 32'hFFFF_0000;
  localparam logic [31:0] SW_ADDR_DEF  = 32'hFFFF_0004;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_req_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for slow asynchronous inputs.
// Synchronous active-high reset clears both stages.
module sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/dmem_bus_responder.sv
// Handshaked data-memory responder: RAM, LED and switch MMIO.
// Define DMEM_BUS_ERR_EN to flag unmapped/misaligned/SW-store accesses.
module dmem_bus_responder
  import rv32_pkg::*;
#(
  parameter int          DEPTH_WORDS = 2048,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] LED_ADDR    = LED_ADDR_DEF,
  parameter logic [31:0] SW_ADDR     = SW_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic [7:0]  sw,
  output logic [7:0]  led
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0] ram [DEPTH_WORDS];

  bus_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  bus_req_t    req_q, req_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  led_q, led_d;
  logic [7:0]  sw_sync;

  bus_req_t    in_req, ex_req;
  logic        exec;
  logic        aligned, ram_hit, led_hit, sw_hit, mapped;
  logic        ram_we;
  logic [31:0] rd;
  logic        err;
  logic [AW-1:0] widx;

  sync2 #(.W(8)) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw),
    .q   (sw_sync)
  );

  assign req_ready = (state_q == IDLE) && !rst;
  assign in_req    = '{we: req_we, addr: req_addr,
                       wdata: req_wdata, be: req_be};

  // With zero wait states execution uses the live request.
  assign ex_req  = (state_q == IDLE) ? in_req : req_q;

  assign aligned = ex_req.addr[1:0] == 2'b00;
  assign ram_hit = ex_req.addr < RAM_BYTES;
  assign led_hit = ex_req.addr == LED_ADDR;
  assign sw_hit  = ex_req.addr == SW_ADDR;
  assign mapped  = aligned && (ram_hit || led_hit || sw_hit);
  assign widx    = ex_req.addr[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    exec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d = in_req;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            exec    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          exec    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd = '0;
    if (!ex_req.we && aligned) begin
      unique case (1'b1)
        ram_hit: rd = ram[widx];
        led_hit: rd = {24'b0, led_q};
        sw_hit:  rd = {24'b0, sw_sync};
        default: rd = '0;
      endcase
    end
  end

  always_comb begin
`ifdef DMEM_BUS_ERR_EN
    err = !mapped || (ex_req.we && sw_hit);
`else
    err = 1'b0;
`endif
  end

  always_comb begin
    rsp_valid_d = state_d == RESP;
    rsp_rdata_d = exec ? rd : rsp_rdata_q;
    rsp_err_d   = exec ? err : rsp_err_q;
    led_d       = led_q;
    if (exec && ex_req.we && mapped && led_hit && ex_req.be[0])
      led_d = ex_req.wdata[7:0];
  end

  assign ram_we = exec && !rst && ex_req.we && mapped && ram_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      led_q       <= led_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ex_req.be[b])
          ram[widx][8*b +: 8] <= ex_req.wdata[8*b +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign led       = led_q;

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Directed bench for dmem_bus_responder (WAIT_CYCLES=1).
// Error-flag expectations follow DMEM_BUS_ERR_EN.
module tb_dmem_bus_responder;

`ifdef DMEM_BUS_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  sw = '0;
  logic [7:0]  led;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_bus_responder #(
    .DEPTH_WORDS (2048),
    .WAIT_CYCLES (1),
    .LED_ADDR    (32'hFFFF_0000),
    .SW_ADDR     (32'hFFFF_0004)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .sw        (sw),
    .led       (led)
  );

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, return cycles from accept cycle to rsp_valid.
  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       output int lat);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("rsp_arrives", 32'(rsp_valid), 32'd1);
  endtask

  task automatic done_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output logic [31:0] rd, output logic e);
    int lat;
    issue(we, a, d, be, lat);
    rd = rsp_rdata;
    e  = rsp_err;
    done_rsp();
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;

    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_req_ready_after", 32'(req_ready), 32'd1);

    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat);
    chk("store_latency", 32'(lat), 32'd2);
    chk("store_rdata_zero", rsp_rdata, 32'h0);
    chk("store_err", 32'(rsp_err), 32'd0);
    done_rsp();
    chk("req_ready_after_store", 32'(req_ready), 32'd1);

    issue(1'b0, 32'h10, 32'h0, 4'h0, lat);
    chk("load_latency", 32'(lat), 32'd2);
    chk("load_data", rsp_rdata, 32'hDEADBEEF);
    chk("load_err", 32'(rsp_err), 32'd0);
    done_rsp();

    xfer(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, e);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, e);
    chk("byte_enable_merge", rd, 32'hDE22BE44);

    xfer(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, e);
    chk("be0_ack_err", 32'(e), 32'd0);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, e);
    chk("be0_noop", rd, 32'hDE22BE44);

    issue(1'b0, 32'h10, 32'h0, 4'h0, lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hDE22BE44);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    done_rsp();
    chk("bp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("bp_req_ready_back", 32'(req_ready), 32'd1);

    issue(1'b1, 32'hFFFF_0000, 32'h000000A5, 4'h1, lat);
    chk("led_in_resp", 32'(led), 32'hA5);
    done_rsp();
    xfer(1'b1, 32'hFFFF_0000, 32'h0000005A, 4'h2, rd, e);
    chk("led_be0_only", 32'(led), 32'hA5);
    xfer(1'b0, 32'hFFFF_0000, 32'h0, 4'h0, rd, e);
    chk("led_readback", rd, 32'h000000A5);

    sw = 8'h3C;
    tick();
    tick();
    tick();
    xfer(1'b0, 32'hFFFF_0004, 32'h0, 4'h0, rd, e);
    chk("sw_read", rd, 32'h0000003C);
    chk("sw_read_err", 32'(e), 32'd0);

    xfer(1'b0, 32'h12, 32'h0, 4'h0, rd, e);
    chk("misalign_load_data", rd, 32'h0);
    chk("misalign_load_err", 32'(e), 32'(EXP_ERR));

    xfer(1'b1, 32'h11, 32'h0, 4'hF, rd, e);
    chk("misalign_store_err", 32'(e), 32'(EXP_ERR));
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, e);
    chk("misalign_store_nochg", rd, 32'hDE22BE44);

    xfer(1'b1, 32'h0, 32'h12345678, 4'hF, rd, e);
    xfer(1'b1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF, rd, e);
    chk("unmapped_store_err", 32'(e), 32'(EXP_ERR));
    xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, e);
    chk("unmapped_store_nochg", rd, 32'h12345678);

    xfer(1'b0, 32'h0000_2000, 32'h0, 4'h0, rd, e);
    chk("unmapped_load_data", rd, 32'h0);
    chk("unmapped_load_err", 32'(e), 32'(EXP_ERR));

    xfer(1'b1, 32'hFFFF_0004, 32'h000000FF, 4'hF, rd, e);
    chk("sw_store_err", 32'(e), 32'(EXP_ERR));
    chk("sw_store_led", 32'(led), 32'hA5);

    xfer(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, e);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h0BAD0BAD;
    req_be    = 4'hF;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_led", 32'(led), 32'h0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    tick();
    tick();
    chk("mid_rst_still_no_rsp", 32'(rsp_valid), 32'd0);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, rd, e);
    chk("mid_rst_store_dropped", rd, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
